periph_handshake_arbiter: RTL and testbench



---
 rtl/periph_handshake_arbiter.sv | 94 +++++++++
 tb/tb_periph_handshake_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/periph_handshake_arbiter.sv
// Bridges one 4-phase processor request to peripheral 1 or 2, with a timeout on the peripheral handshake.
// Latency: request sampled to proc_ack is 3 cycles minimum; processor is held in DONE/ERR until proc_send drops.
module periph_handshake_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              proc_send,
  input  logic              proc_sel,
  input  logic [DATA_W-1:0] proc_data,
  output logic              proc_ack,
  output logic              proc_err,
  output logic              p1_send,
  output logic [DATA_W-1:0] p1_data,
  input  logic              p1_ack,
  output logic              p2_send,
  output logic [DATA_W-1:0] p2_data,
  input  logic              p2_ack,
  output logic              busy
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, SEND, DROP, DONE, ERR} state_t;

  state_t          state, state_n;
  logic            sel_q, sel_n;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            ack_sel;
  logic            tmo;

  assign accept  = (state == IDLE) && proc_send;
  assign ack_sel = sel_q ? p2_ack : p1_ack;
  assign tmo     = (cnt == CW'(TIMEOUT - 1));

  // A sampled exit condition wins over an expiring timeout in the same cycle.
  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    case (state)
      IDLE: if (proc_send) begin
        state_n = SEND;
        sel_n   = proc_sel;
      end
      SEND: begin
        if (ack_sel)  state_n = DROP;
        else if (tmo) state_n = ERR;
      end
      DROP: begin
        if (!ack_sel) state_n = DONE;
        else if (tmo) state_n = ERR;
      end
      DONE:    if (!proc_send) state_n = IDLE;
      ERR:     if (!proc_send) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 1'b0;
      cnt      <= '0;
      p1_send  <= 1'b0;
      p2_send  <= 1'b0;
      p1_data  <= '0;
      p2_data  <= '0;
      proc_ack <= 1'b0;
      proc_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_n;
      sel_q <= sel_n;
      if (state_n != state) begin
        cnt <= '0;
      end else if ((state == SEND) || (state == DROP)) begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        p1_data <= proc_sel ? '0 : proc_data;
        p2_data <= proc_sel ? proc_data : '0;
      end
      p1_send  <= (state_n == SEND) && !sel_n;
      p2_send  <= (state_n == SEND) && sel_n;
      proc_ack <= (state_n == DONE) || (state_n == ERR);
      proc_err <= (state_n == ERR);
      busy     <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_periph_handshake_arbiter.sv
// Bench for periph_handshake_arbiter: expected waveforms come from per-transaction timing arithmetic.
// Peripherals are modelled as fixed-delay responders; stray acks and data churn are randomized.
module tb_periph_handshake_arbiter;

  localparam int DW = 8;
  localparam int T  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          proc_send, proc_sel;
  logic [DW-1:0] proc_data;
  logic          proc_ack, proc_err;
  logic          p1_send, p2_send;
  logic [DW-1:0] p1_data, p2_data;
  logic          p1_ack, p2_ack;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] prev1 = '0;
  logic [DW-1:0] prev2 = '0;

  periph_handshake_arbiter #(.DATA_W(DW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .proc_send(proc_send), .proc_sel(proc_sel), .proc_data(proc_data),
    .proc_ack(proc_ack), .proc_err(proc_err),
    .p1_send(p1_send), .p1_data(p1_data), .p1_ack(p1_ack),
    .p2_send(p2_send), .p2_data(p2_data), .p2_ack(p2_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the cycle proc_send is first high. Peripheral acks in cycle 1+a and
  // releases ack in cycle 2+a+b; the processor drops proc_send r cycles after proc_ack rises.
  // a or b >= T means that phase never completes. chg: 0 steady, 1 data->all ones, 2 random sel/data.
  task automatic run_txn(input logic sel, input logic [DW-1:0] data, input int a, input int b,
                         input int r, input int g, input bit stray, input int chg,
                         output int send_cycles);
    int send_end, fin, last;
    bit err, sack, send_e, ack_e, busy_e;
    logic [4:0] exp_ctl, act_ctl;
    logic [DW-1:0] e1, e2;
    if (a <= T - 1) begin
      send_end = 1 + a;
      if (b <= T - 1) begin fin = 3 + a + b; err = 1'b0; end
      else            begin fin = 2 + a + T; err = 1'b1; end
    end else begin
      send_end = T;
      fin      = T + 1;
      err      = 1'b1;
    end
    last = fin + r;
    send_cycles = 0;
    for (int c = 0; c <= last + g; c++) begin
      @(posedge clk); #1;
      proc_send = (c < last);
      if (c == 0) begin
        proc_sel  = sel;
        proc_data = data;
      end else if (chg == 1) begin
        proc_data = '1;
      end else if (chg == 2) begin
        proc_sel  = 1'($urandom_range(0, 1));
        proc_data = DW'($urandom);
      end
      sack = (a <= T - 1) && (c >= 1 + a) && ((c <= 1 + a + b) || (b > T - 1)) && (c <= last);
      if (c > last && stray) sack = 1'($urandom_range(0, 1));
      if (sel) begin
        p2_ack = sack;
        p1_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        p1_ack = sack;
        p2_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      busy_e  = (c >= 1) && (c <= last);
      send_e  = (c >= 1) && (c <= send_end);
      ack_e   = (c >= fin) && (c <= last);
      exp_ctl = {sel ? 1'b0 : send_e, sel ? send_e : 1'b0, ack_e, err && ack_e, busy_e};
      act_ctl = {p1_send, p2_send, proc_ack, proc_err, busy};
      e1 = (c == 0) ? prev1 : (sel ? '0 : data);
      e2 = (c == 0) ? prev2 : (sel ? data : '0);
      checks++;
      if (act_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL ctl cycle %0d {p1s,p2s,ack,err,busy}: got %b want %b", c, act_ctl, exp_ctl);
      end
      checks++;
      if (p1_data !== e1) begin
        errors++;
        $display("FAIL p1_data cycle %0d: got %h want %h", c, p1_data, e1);
      end
      checks++;
      if (p2_data !== e2) begin
        errors++;
        $display("FAIL p2_data cycle %0d: got %h want %h", c, p2_data, e2);
      end
      if (p1_send || p2_send) send_cycles++;
    end
    p1_ack = 1'b0;
    p2_ack = 1'b0;
    prev1 = sel ? '0 : data;
    prev2 = sel ? data : '0;
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    rst = 1'b1;
    proc_send = 1'($urandom_range(0, 1)); proc_sel = 1'($urandom_range(0, 1));
    proc_data = DW'($urandom); p1_ack = 1'($urandom_range(0, 1)); p2_ack = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      outs = {p1_send, p2_send, |p1_data, |p2_data, proc_ack, proc_err, busy};
      checks++;
      if (outs !== 7'b0) begin
        errors++;
        $display("FAIL reset cycle %0d outputs nonzero: got %b want 0000000", i, outs);
      end
      proc_sel = 1'($urandom_range(0, 1)); proc_data = DW'($urandom);
      p1_ack = 1'($urandom_range(0, 1)); p2_ack = 1'($urandom_range(0, 1));
      if (i < 2) begin
        proc_send = 1'($urandom_range(0, 1));
      end else begin
        rst = 1'b0;
        proc_send = 1'b0;
      end
    end
    prev1 = '0;
    prev2 = '0;
  endtask

  task automatic test_p1_transfer();
    int sc;
    run_txn(1'b0, 8'hA5, 3, 2, 2, 1, 1'b0, 0, sc);
    checks++;
    if (sc !== 4) begin
      errors++;
      $display("FAIL p1_send_len: got %0d want 4", sc);
    end
  endtask

  task automatic test_p2_data_change();
    int sc;
    run_txn(1'b1, 8'h3C, 1, 1, 1, 1, 1'b0, 1, sc);
    checks++;
    if (sc !== 2) begin
      errors++;
      $display("FAIL p2_send_len: got %0d want 2", sc);
    end
  endtask

  task automatic test_timeout();
    int sc;
    run_txn(1'b0, 8'h5A, T + 5, 0, 2, 1, 1'b0, 0, sc);
    checks++;
    if (sc !== T) begin
      errors++;
      $display("FAIL timeout_send_len: got %0d want %0d", sc, T);
    end
  endtask

  task automatic test_stray_acks();
    int sc;
    logic [4:0] act_ctl;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      proc_send = 1'b0;
      p1_ack = 1'b0;
      p2_ack = i[0];
      act_ctl = {p1_send, p2_send, proc_ack, proc_err, busy};
      checks++;
      if (act_ctl !== 5'b0 || p1_data !== prev1 || p2_data !== prev2) begin
        errors++;
        $display("FAIL stray_idle cycle %0d: ctl %b p1d %h p2d %h want ctl 00000 p1d %h p2d %h",
                 i, act_ctl, p1_data, p2_data, prev1, prev2);
      end
    end
    run_txn(1'b0, 8'h96, 4, 3, 1, 1, 1'b1, 0, sc);
  endtask

  task automatic test_reset_mid_send();
    int sc;
    logic [6:0] outs;
    @(posedge clk); #1;
    proc_send = 1'b1; proc_sel = 1'b0; proc_data = 8'h77;
    p1_ack = 1'b0; p2_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (p1_send !== 1'b1 || p1_data !== 8'h77) begin
      errors++;
      $display("FAIL midrst_pre: p1_send %b p1_data %h want 1 77", p1_send, p1_data);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    outs = {p1_send, p2_send, |p1_data, |p2_data, proc_ack, proc_err, busy};
    checks++;
    if (outs !== 7'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got %b want 0000000", outs);
    end
    rst = 1'b0;
    proc_send = 1'b0;
    prev1 = '0;
    prev2 = '0;
    run_txn(1'b1, 8'hC3, 0, 0, 1, 1, 1'b0, 0, sc);
  endtask

  task automatic test_back_to_back_random();
    int sc;
    for (int n = 0; n < 30; n++) begin
      run_txn(1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, T + 2),
              $urandom_range(0, T + 2), $urandom_range(1, 3), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), $urandom_range(0, 2), sc);
    end
  endtask

  initial begin
    test_reset();
    test_p1_transfer();
    test_p2_data_change();
    test_timeout();
    test_stray_acks();
    test_reset_mid_send();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
